// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_S1    = 3'd2,
    ST_S2    = 3'd3,
    ST_S3    = 3'd4,
    ST_FAULT = 3'd5
  } ifu_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam int          DEFAULT_ACK_TIMEOUT = 16;

  // Instruction phase reported to decode for each state
  function automatic logic [1:0] stage_of(input ifu_state_e s);
    case (s)
      ST_S1:    return 2'd1;
      ST_S2:    return 2'd2;
      ST_S3:    return 2'd3;
      ST_FAULT: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  // Instructions are 32-bit aligned; any other fetch address is a fault
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : ifu_watchdog
// Purpose  : Counts fetch cycles spent waiting for a memory acknowledge and
//            flags expiry on the cycle that would reach ACK_TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_watchdog #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(ACK_TIMEOUT + 1);

  logic [W-1:0] count;

  // Expiry is flagged during the last allowed waiting cycle so the owner
  // can leave on that same edge.
  assign expired = enable && (count == W'(ACK_TIMEOUT - 1));

  // Count waiting cycles; clearing restarts the budget for a new fetch
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_top.sv
`default_nettype none
// ============================================================================
// Module   : ifu_top
// Purpose  : Instruction fetch unit. Issues one read per instruction, holds
//            it for three decode phases, then advances or redirects the PC.
//            Misaligned targets and missing acknowledges park in FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_top
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        soc_clk,
  input  logic        IFU_reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [31:0] pc_increment,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [1:0]  stage_counter,
  output logic [31:0] pc,
  output logic        fetch_fault
);

  ifu_state_e  state, state_next;
  logic [31:0] pc_next;
  logic        wd_expired;

  // Watchdog restarts whenever we are outside FETCH, so every entry starts at 0
  ifu_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_watchdog (
    .clk    (soc_clk),
    .rst    (IFU_reset),
    .clear  (state != ST_FETCH),
    .enable ((state == ST_FETCH) && !mem_ack),
    .expired(wd_expired)
  );

  // Next-state and next-PC selection
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_IDLE:  state_next = is_aligned(pc) ? ST_FETCH : ST_FAULT;
      ST_FETCH: begin
        if (mem_ack) begin
          state_next = ST_S1;
        end else if (wd_expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_S1:    state_next = ST_S2;
      ST_S2:    state_next = ST_S3;
      ST_S3: begin
        if (!stall) begin
          // Redirect targets are halfword-aligned by dropping bit 0
          pc_next    = redirect_valid ? (redirect_pc & ~32'h1) : (pc + pc_increment);
          state_next = is_aligned(pc_next) ? ST_FETCH : ST_FAULT;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, PC, instruction latch and sticky fault flag
  always_ff @(posedge soc_clk) begin
    if (IFU_reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if ((state == ST_FETCH) && mem_ack) begin
        instruction <= mem_rdata;
      end
      if (state_next == ST_FAULT) begin
        fetch_fault <= 1'b1;
      end
    end
  end

  assign mem_req       = (state == ST_FETCH);
  assign mem_addr      = pc;
  assign stage_counter = stage_of(state);

endmodule
`default_nettype wire

// File: tb/tb_ifu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_top
// Purpose  : Self-checking bench for ifu_top with a reference PC model and
//            a scoreboard for fetch addresses and latched instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_top;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        soc_clk = 1'b0;
  logic        IFU_reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] pc_increment = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] instruction;
  logic [1:0]  stage_counter;
  logic [31:0] pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] model_pc;

  ifu_top #(.RESET_PC(RST_PC), .ACK_TIMEOUT(16)) dut (
    .soc_clk       (soc_clk),
    .IFU_reset     (IFU_reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .pc_increment  (pc_increment),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .instruction   (instruction),
    .stage_counter (stage_counter),
    .pc            (pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 soc_clk = ~soc_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  // Monitor: compare each new fetch address and each newly latched instruction
  logic       prev_req = 1'b0;
  logic [1:0] prev_sc  = 2'd0;
  always @(negedge soc_clk) begin
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL fetch_addr: unexpected fetch at %h, none expected", mem_addr);
      end else begin
        chk("fetch_addr", mem_addr, exp_addr_q.pop_front());
      end
    end
    if (stage_counter === 2'd1 && prev_sc === 2'd0) begin
      if (exp_instr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL instr_latch: unexpected S1 entry with %h, none expected", instruction);
      end else begin
        chk("instr_latch", instruction, exp_instr_q.pop_front());
      end
    end
    prev_req = mem_req;
    prev_sc  = stage_counter;
  end

  // Bounded wait for a fetch request
  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (mem_req !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_req: mem_req %b required 1 within 60 cycles", mem_req);
    end
  endtask

  // One instruction: ack after d waiting cycles, nstall stall cycles in the
  // last phase, then advance by redirect or increment.
  task automatic txn(input int d, input logic [31:0] rdata, input int nstall,
                     input bit redir, input logic [31:0] rpc, input logic [31:0] inc);
    logic [31:0] nxt;
    wait_req();
    chk("fetch_stage", {30'd0, stage_counter}, 32'd0);
    chk("fetch_pc", pc, model_pc);
    mem_ack = 1'b0;
    for (int i = 0; i < d; i++) begin
      redirect_valid = 1'($urandom_range(0, 1));
      pc_increment   = $urandom();
      tick();
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    exp_instr_q.push_back(rdata);
    tick();
    chk("s1_stage", {30'd0, stage_counter}, 32'd1);
    // ack and redirect noise outside FETCH/S3 must be ignored
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
    redirect_valid = 1'b1; pc_increment = $urandom();
    tick();
    chk("s2_stage", {30'd0, stage_counter}, 32'd2);
    tick();
    chk("s3_stage", {30'd0, stage_counter}, 32'd3);
    chk("s3_instr", instruction, rdata);
    stall = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      redirect_valid = 1'($urandom_range(0, 1)); pc_increment = $urandom();
      tick();
      chk("stall_stage", {30'd0, stage_counter}, 32'd3);
      chk("stall_pc", pc, model_pc);
    end
    stall = 1'b0; mem_ack = 1'b0;
    redirect_valid = redir; redirect_pc = rpc; pc_increment = inc;
    nxt = redir ? {rpc[31:1], 1'b0} : model_pc + inc;
    if (nxt[1:0] == 2'b00) exp_addr_q.push_back(nxt);
    tick();
    redirect_valid = 1'b0; pc_increment = '0;
    model_pc = nxt;
    chk("pc_update", pc, model_pc);
  endtask

  task automatic do_reset();
    IFU_reset = 1'b1;
    tick();
    tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", mem_addr, RST_PC);
    chk("rst_instr", instruction, NOP);
    chk("rst_stage", {30'd0, stage_counter}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    model_pc = RST_PC;
    exp_addr_q.push_back(RST_PC);
    IFU_reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int n;
    tick();
    do_reset();

    // First instruction and its phases
    txn(0, 32'h0050_0093, 0, 1'b0, '0, 32'd4);
    // Step to 8, then jump back by 8 to 0
    txn(1, 32'h1111_1111, 0, 1'b0, '0, 32'd4);
    txn(0, 32'h2222_2222, 0, 1'b0, '0, 32'hFFFF_FFF8);
    // Wrap-around: redirect to top of memory, then +4 wraps to 0
    txn(0, 32'h3333_3333, 0, 1'b1, 32'hFFFF_FFFC, 32'd8);
    txn(2, 32'h4444_4444, 0, 1'b0, '0, 32'd4);
    // Redirect wins over increment and drops bit 0
    txn(0, 32'h5555_5555, 0, 1'b1, 32'h0000_0101, 32'd4);
    // Five-cycle stall
    txn(0, 32'h6666_6666, 5, 1'b0, '0, 32'd4);

    // Randomized traffic with aligned targets
    for (int k = 0; k < 40; k++) begin
      r = $urandom();
      txn($urandom_range(0, 4), $urandom(), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0), r & 32'hFFFF_FFFD, $urandom() & 32'hFFFF_FFFC);
    end

    // Ack on the 15th waiting cycle still completes normally
    txn(14, 32'h7777_7777, 0, 1'b0, '0, 32'd4);

    // No ack: FAULT after the 16th FETCH cycle
    wait_req();
    mem_ack = 1'b0;
    repeat (15) tick();
    chk("wd_still_fetch", {31'd0, mem_req}, 32'd1);
    tick();
    chk("wd_fault", {31'd0, fetch_fault}, 32'd1);
    chk("wd_req", {31'd0, mem_req}, 32'd0);
    chk("wd_stage", {30'd0, stage_counter}, 32'd3);
    chk("wd_pc", pc, model_pc);
    mem_ack = 1'b1;
    repeat (3) tick();
    chk("wd_terminal", {31'd0, fetch_fault}, 32'd1);
    chk("wd_terminal_pc", pc, model_pc);
    mem_ack = 1'b0;

    // Reset mid-fetch, then a stale ack while idle
    do_reset();
    wait_req();
    IFU_reset = 1'b1;
    tick();
    IFU_reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("abandon_req", {31'd0, mem_req}, 32'd0);
    chk("abandon_instr", instruction, NOP);
    exp_addr_q.push_back(RST_PC);
    tick();
    mem_ack = 1'b0;
    chk("refetch_req", {31'd0, mem_req}, 32'd1);
    chk("refetch_instr", instruction, NOP);
    model_pc = RST_PC;

    // Misaligned increment from 0: FAULT at pc=2, never requests
    txn(0, 32'h0000_0013, 0, 1'b0, '0, 32'd2);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b0) n++;
      tick();
    end
    chk("mis_no_req", n, 32'd0);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_pc", pc, 32'd2);
    chk("mis_stage", {30'd0, stage_counter}, 32'd3);

    // Recovery
    do_reset();
    repeat (4) tick();
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("instr_q_empty", exp_instr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_top.md
IFU_TOP -- requirements
Module: IFU_top

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, first fetch address; ACK_TIMEOUT, 16, maximum wait cycles for mem_ack.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- soc_clk in 1: single clock, all logic on rising edge
- IFU_reset in 1: synchronous, active-high reset
- mem_req out 1: instruction read request
- mem_addr out 32: read address, equal to pc
- mem_rdata in 32: read data
- mem_ack in 1: read data valid
- pc_increment in 32: PC offset from decode stage
- redirect_valid in 1: absolute target from CU (JALR, trap)
- redirect_pc in 32: absolute target
- stall in 1: hold in stage 3
- instruction out 32: latched instruction to decode
- stage_counter out 2: instruction phase
- pc out 32: address of current instruction
- fetch_fault out 1: sticky fault flag

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, S1, S2, S3 and FAULT.
REQ-004 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-005 In FETCH, mem_req SHALL be 1 and stage_counter SHALL be 0; in all other states mem_req SHALL be 0.
REQ-006 In FETCH, mem_ack=1 SHALL latch mem_rdata into instruction and move to S1 on that edge.
REQ-007 S1 SHALL move to S2 and S2 SHALL move to S3, one cycle each, with stage_counter 1 and 2.
REQ-008 In S3, stage_counter SHALL be 3.
REQ-009 In S3 with stall=1, the state and all outputs SHALL hold.
REQ-010 In S3 with stall=0, pc SHALL update and the state SHALL move to FETCH.
- PC update: redirect_valid=1 gives {redirect_pc[31:1],1'b0}; otherwise pc+pc_increment.
- Arithmetic is modulo 2^32 with wrap-around and no flag.
REQ-011 redirect_valid and pc_increment SHALL be sampled only in S3 with stall=0; redirect SHALL take priority.
REQ-012 instruction SHALL be stable from entry to S1 until the next mem_ack.
REQ-013 Minimum instruction period SHALL be 4 cycles when mem_ack arrives in the first FETCH cycle.
REQ-014 On entering FETCH with pc[1:0]!=2'b00, the block SHALL go to FAULT instead: fetch_fault=1 and no mem_req is issued.
REQ-015 A watchdog SHALL count FETCH cycles without mem_ack.
- On reaching ACK_TIMEOUT the block SHALL go to FAULT.
- The counter SHALL clear on every FETCH entry.
REQ-016 FAULT SHALL be terminal until IFU_reset, with stage_counter=3, mem_req=0 and pc holding the faulting address.
REQ-017 mem_ack outside FETCH SHALL be ignored.
REQ-018 mem_addr SHALL always equal pc.

Reset
REQ-019 While IFU_reset=1 at a clock edge, the block SHALL set the following, overriding all other inputs:
- state=IDLE
- pc=mem_addr=RESET_PC
- instruction=32'h0000_0013 (NOP)
- stage_counter=0, mem_req=0, fetch_fault=0
- watchdog=0
REQ-020 Reset asserted mid-fetch or mid-stall SHALL abandon the transaction; a later stale mem_ack SHALL be ignored per REQ-017.

Structure
REQ-021 A shared package IFU_pkg SHALL hold the state enum, the NOP constant and the default RESET_PC and ACK_TIMEOUT.
REQ-022 The watchdog SHALL be the sub-module IFU_watchdog: clear, enable, expired output, width $clog2(ACK_TIMEOUT+1).
REQ-023 stage_counter SHALL drive IDU_top.stage_counter directly, and IDU_top.pc_increment SHALL drive pc_increment.

Verification
REQ-024 Reset, then mem_ack on the first FETCH cycle with rdata 32'h00500093 -> instruction=00500093, stage_counter 0,1,2,3, and pc 0->4 on leaving S3.
REQ-025 pc=8, pc_increment=32'hFFFF_FFF8 (JAL -8) -> next mem_addr=0; pc=32'hFFFF_FFFC, pc_increment=4 -> mem_addr=0 (wrap-around).
REQ-026 In S3, redirect_valid=1, redirect_pc=32'h0000_0101, pc_increment=4 -> pc=32'h0000_0100; redirect wins.
REQ-027 pc_increment=2 from pc=0 -> FAULT with fetch_fault=1, mem_req never asserted, and pc=2 held; IFU_reset then recovers to pc=RESET_PC.
REQ-028 mem_ack withheld for 16 FETCH cycles -> FAULT on the 16th; a separate run with ack on cycle 15 -> normal S1 entry.
REQ-029 stall=1 for 5 cycles in S3 -> stage_counter=3 and pc unchanged throughout; reset asserted during FETCH followed by a late ack -> IDLE, then a fresh FETCH from RESET_PC.
